// File: rtl/seq_pkg.sv
// seq_pkg: shared state type and default pattern for the serial pattern source
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} seq_state_t;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: parallel-load, shift-left register exposing its MSB
module seq_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);
  logic [WIDTH-1:0] sr_q, sr_d;
  always_comb sr_d = load_i ? data_i : shift_i ? {sr_q[WIDTH-2:0], 1'b0} : sr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr_q <= '0;
    else sr_q <= sr_d;
  assign msb_o = sr_q[WIDTH-1];
endmodule

// File: rtl/sequence_transmitter.sv
// sequence_transmitter: shifts a loaded pattern out MSB-first for repeat+1 frames with optional idle gaps
module sequence_transmitter
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   CNT_W      = 4,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_in,
  input  logic             abort,
  output logic             load_ready,
  output logic             data_out,
  output logic             data_valid,
  output logic             frame_done,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP > 0 ? GAP - 1 : 0);
  seq_state_t       state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] frm_q, frm_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] pat_q, pat_d, ld_pat;
  logic             dout_q, dout_d, dval_q, dval_d, done_q, done_d;
  logic             ld, sh, msb;
  // The register holds the bits still to come; the bit on data_out lives in dout_q.
  seq_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld),
    .shift_i(sh),
    .data_i ({ld_pat[WIDTH-2:0], 1'b0}),
    .msb_o  (msb)
  );
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    frm_d   = frm_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    ld_pat  = pat_q;
    ld      = 1'b0;
    sh      = 1'b0;
    dout_d  = IDLE_LEVEL;
    dval_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      seq_pkg::IDLE:
        if (load_valid) begin
          state_d = seq_pkg::SHIFT;
          pat_d   = pattern_in;
          ld_pat  = pattern_in;
          frm_d   = repeat_in;
          bit_d   = '0;
          ld      = 1'b1;
        end
      seq_pkg::SHIFT:
        if (abort) begin
          state_d = seq_pkg::IDLE;
          bit_d   = '0;
        end else if (bit_q != LAST) begin
          sh     = 1'b1;
          bit_d  = bit_q + 1'b1;
          dout_d = msb;
          dval_d = 1'b1;
          done_d = bit_d == LAST;
        end else if (frm_q == '0) begin
          state_d = seq_pkg::IDLE;
          bit_d   = '0;
        end else begin
          frm_d   = frm_q - 1'b1;
          bit_d   = '0;
          gap_d   = '0;
          ld      = GAP == 0;
          state_d = GAP == 0 ? seq_pkg::SHIFT : seq_pkg::GAP;
        end
      seq_pkg::GAP:
        if (abort) begin
          state_d = seq_pkg::IDLE;
          gap_d   = '0;
        end else if (gap_q == GLAST) begin
          state_d = seq_pkg::SHIFT;
          gap_d   = '0;
          ld      = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      default: state_d = seq_pkg::IDLE;
    endcase
    if (ld) begin
      dout_d = ld_pat[WIDTH-1];
      dval_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= seq_pkg::IDLE;
      bit_q   <= '0;
      frm_q   <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      dout_q  <= IDLE_LEVEL;
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      done_q  <= done_d;
    end
  assign load_ready = state_q == seq_pkg::IDLE;
  assign busy       = !load_ready;
  assign data_out   = dout_q;
  assign data_valid = dval_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_sequence_transmitter.sv
// tb_sequence_transmitter: table and random bursts on a GAP=0 and a GAP=2 instance against a timing-formula model
module tb_sequence_transmitter;
  import seq_pkg::*;
  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  rep;
    bit          abt;
    int          intr;
    int          len0;
    int          len2;
    int          done;
    logic [31:0] s0;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, load_valid = 1'b0, abort = 1'b0;
  logic [3:0] pattern_in = '0, repeat_in = '0;
  logic r0, o0, v0, f0, b0, r2, o2, v2, f2, b2;
  int checks = 0, errors = 0;
  vec_t vecs[3];
  always #5 clk = ~clk;
  sequence_transmitter #(.WIDTH(4), .CNT_W(4), .GAP(0), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .pattern_in(pattern_in),
    .repeat_in(repeat_in), .abort(abort), .load_ready(r0), .data_out(o0),
    .data_valid(v0), .frame_done(f0), .busy(b0)
  );
  sequence_transmitter #(.WIDTH(4), .CNT_W(4), .GAP(2), .IDLE_LEVEL(1'b1)) u2 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .pattern_in(pattern_in),
    .repeat_in(repeat_in), .abort(abort), .load_ready(r2), .data_out(o2),
    .data_valid(v2), .frame_done(f2), .busy(b2)
  );
  // Expected {busy, data_out, data_valid, frame_done} in cycle t after acceptance (t=0: idle).
  function automatic logic [3:0] model(input logic [3:0] pat, input int rep, input int g, input logic lvl, input int t);
    int len, pos, idx;
    logic v, bz;
    len = (rep + 1) * 4 + rep * g;
    pos = (t - 1) % (4 + g);
    bz  = t >= 1 && t <= len;
    v   = bz && pos < 4;
    idx = v ? 3 - pos : 0;
    return {bz, v ? pat[idx] : lvl, v, v && pos == 3};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [3:0] e, input logic r, input logic b, input logic o, input logic v, input logic f);
    chk({tag, " busy"}, {31'b0, b}, {31'b0, e[3]});
    chk({tag, " load_ready"}, {31'b0, r}, {31'b0, !e[3]});
    chk({tag, " data_out"}, {31'b0, o}, {31'b0, e[2]});
    chk({tag, " data_valid"}, {31'b0, v}, {31'b0, e[1]});
    chk({tag, " frame_done"}, {31'b0, f}, {31'b0, e[0]});
  endtask
  task automatic idle_both(input string tag);
    cyc({tag, " g0"}, model(4'b0, 0, 0, 1'b0, 0), r0, b0, o0, v0, f0);
    cyc({tag, " g2"}, model(4'b0, 0, 2, 1'b1, 0), r2, b2, o2, v2, f2);
  endtask
  task automatic start(input logic [3:0] pat, input logic [3:0] rep, input bit abt);
    @(negedge clk);
    load_valid = 1'b1;
    pattern_in = pat;
    repeat_in  = rep;
    abort      = abt;
    @(negedge clk);
    load_valid = 1'b0;
    abort      = 1'b0;
  endtask
  task automatic check_cycle(input string tag, input logic [3:0] pat, input int rep, input int t);
    cyc($sformatf("%s g0 t%0d", tag, t), model(pat, rep, 0, 1'b0, t), r0, b0, o0, v0, f0);
    cyc($sformatf("%s g2 t%0d", tag, t), model(pat, rep, 2, 1'b1, t), r2, b2, o2, v2, f2);
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    int bz0, bz2, dn0, dn2, len2;
    logic [31:0] s0;
    bz0 = 0; bz2 = 0; dn0 = 0; dn2 = 0; s0 = '0;
    len2 = (int'(v.rep) + 1) * 4 + int'(v.rep) * 2;
    start(v.pat, v.rep, v.abt);
    for (int t = 1; t <= len2 + 1; t++) begin
      check_cycle(tag, v.pat, int'(v.rep), t);
      bz0 += int'(b0); bz2 += int'(b2); dn0 += int'(f0); dn2 += int'(f2);
      if (t <= v.len0) s0 = {s0[30:0], o0};
      if (t == v.intr) begin
        load_valid = 1'b1;
        pattern_in = ~v.pat;
        repeat_in  = 4'hf;
      end else load_valid = 1'b0;
      @(negedge clk);
    end
    load_valid = 1'b0;
    chk({tag, " busy cycles g0"}, bz0, v.len0);
    chk({tag, " busy cycles g2"}, bz2, v.len2);
    chk({tag, " frame_done count g0"}, dn0, v.done);
    chk({tag, " frame_done count g2"}, dn2, v.done);
    chk({tag, " stream g0"}, s0, v.s0);
  endtask
  initial begin
    vecs[0] = '{4'b1011, 4'd0, 1'b1, 0, 4, 4, 1, 32'hB};
    vecs[1] = '{4'b1001, 4'd2, 1'b0, 0, 12, 16, 3, 32'h999};
    vecs[2] = '{4'b1100, 4'd1, 1'b0, 2, 8, 10, 2, 32'hCC};
    repeat (2) @(negedge clk);
    idle_both("reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    start(DEFAULT_PATTERN, 4'd3, 1'b0);
    check_cycle("abort", DEFAULT_PATTERN, 3, 1);
    @(negedge clk);
    check_cycle("abort", DEFAULT_PATTERN, 3, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle_both("after abort");
    @(negedge clk);
    idle_both("after abort+1");
    run_vec("post-abort", '{DEFAULT_PATTERN, 4'd0, 1'b0, 0, 4, 4, 1, 32'hB});
    start(4'b0110, 4'd2, 1'b0);
    check_cycle("rstmid", 4'b0110, 2, 1);
    @(negedge clk);
    check_cycle("rstmid", 4'b0110, 2, 2);
    #2 reset = 1'b1;
    #1 idle_both("async reset");
    #1 reset = 1'b0;
    run_vec("post-reset", vecs[0]);
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      logic [3:0] e;
      v.pat  = 4'($urandom);
      v.rep  = 4'($urandom_range(0, 3));
      v.abt  = 1'($urandom);
      v.len0 = (int'(v.rep) + 1) * 4;
      v.len2 = v.len0 + int'(v.rep) * 2;
      v.done = int'(v.rep) + 1;
      v.intr = int'($urandom_range(0, v.len0));
      v.s0   = '0;
      for (int t = 1; t <= v.len0; t++) begin
        e = model(v.pat, int'(v.rep), 0, 1'b0, t);
        v.s0 = {v.s0[30:0], e[2]};
      end
      run_vec($sformatf("rand%0d", i), v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
